// File: rtl/fir_pkg.sv
// fir_pkg
// Shared definitions for the FIR stream engine: default parameter values and
// the controller state encoding used by fir_stream_engine.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAP_NUM    = 11;
  localparam int DEF_LEN_WIDTH  = 10;

  // Controller states; one sample flows FETCH -> MAC -> OUT per loop.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MAC   = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } fir_state_t;

endpackage

// File: rtl/fir_coef_ram.sv
// fir_coef_ram
// TAP_NUM x DATA_WIDTH coefficient register file with one synchronous write
// port and one combinational read port. Cleared by reset.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   we           write strobe (writes to addresses >= TAP_NUM are dropped)
//   waddr/wdata  write address and data
//   raddr/rdata  combinational read address and data
module fir_coef_ram
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAP_NUM    = DEF_TAP_NUM
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [$clog2(TAP_NUM)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic [$clog2(TAP_NUM)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] coef_q [TAP_NUM];
  logic [DATA_WIDTH-1:0] coef_d [TAP_NUM];

  // The address field can encode more entries than exist when TAP_NUM is
  // not a power of two, so out-of-range writes are filtered here.
  always_comb begin
    coef_d = coef_q;
    if (we && (int'(waddr) < TAP_NUM)) begin
      coef_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q <= '{default: '0};
    end else begin
      coef_q <= coef_d;
    end
  end

  assign rdata = coef_q[raddr];

endmodule

// File: rtl/fir_stream_engine.sv
// fir_stream_engine
// Pops signed samples from a first-word-fall-through FIFO, runs a TAP_NUM-tap
// FIR with one shared multiplier (one MAC per cycle) and emits each result on
// a valid/ready stream. Arithmetic wraps modulo 2^DATA_WIDTH.
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   ap_start, data_length      job start pulse and sample count (IDLE only)
//   ap_idle, ap_done           idle status and one-cycle end-of-job pulse
//   coef_we/addr/wdata         coefficient write port (IDLE only)
//   fifo_empty, fifo_data      FIFO status and head word
//   fifo_r_ready               pop request (pop when high and FIFO not empty)
//   sm_tvalid/tready/tdata/tlast  output stream
module fir_stream_engine
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAP_NUM    = DEF_TAP_NUM,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ap_start,
  input  logic [LEN_WIDTH-1:0]       data_length,
  output logic                       ap_idle,
  output logic                       ap_done,
  input  logic                       coef_we,
  input  logic [$clog2(TAP_NUM)-1:0] coef_addr,
  input  logic [DATA_WIDTH-1:0]      coef_wdata,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  output logic                       fifo_r_ready,
  output logic                       sm_tvalid,
  input  logic                       sm_tready,
  output logic [DATA_WIDTH-1:0]      sm_tdata,
  output logic                       sm_tlast
);

  localparam int              AW       = $clog2(TAP_NUM);
  localparam logic [AW-1:0]   LAST_TAP = AW'(TAP_NUM - 1);

  fir_state_t             state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [AW-1:0]          tap_q, tap_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  hist_q [TAP_NUM];
  logic [DATA_WIDTH-1:0]  hist_d [TAP_NUM];
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tlast_q, tlast_d;
  logic                   tvalid_q, tvalid_d;
  logic                   done_q, done_d;
  logic                   idle_q, idle_d;

  logic [DATA_WIDTH-1:0]  coef_rdata;
  logic [DATA_WIDTH-1:0]  product;
  logic [DATA_WIDTH-1:0]  mac_sum;

  // Coefficients may only change while idle so a running job sees a stable set.
  fir_coef_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAP_NUM    (TAP_NUM)
  ) u_coef_ram (
    .clk   (clk),
    .reset (reset),
    .we    (coef_we && (state_q == S_IDLE)),
    .waddr (coef_addr),
    .wdata (coef_wdata),
    .raddr (tap_q),
    .rdata (coef_rdata)
  );

  // Single shared multiplier; only the low DATA_WIDTH bits are kept, which is
  // the same for signed and unsigned operands.
  assign product = coef_rdata * hist_q[tap_q];
  assign mac_sum = acc_q + product;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    count_d      = count_q;
    tap_d        = tap_q;
    acc_d        = acc_q;
    hist_d       = hist_q;
    tdata_d      = tdata_q;
    tlast_d      = tlast_q;
    fifo_r_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          len_d   = data_length;
          count_d = '0;
          hist_d  = '{default: '0};
          state_d = (data_length == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_r_ready = !fifo_empty;
        if (!fifo_empty) begin
          for (int k = TAP_NUM - 1; k > 0; k--) begin
            hist_d[k] = hist_q[k-1];
          end
          hist_d[0] = fifo_data;
          acc_d     = '0;
          tap_d     = '0;
          state_d   = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        if (tap_q == LAST_TAP) begin
          // Result and last flag are captured once here and held through OUT.
          tdata_d = mac_sum;
          tlast_d = (count_q == (len_q - LEN_WIDTH'(1)));
          state_d = S_OUT;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
      S_OUT: begin
        if (sm_tready) begin
          count_d = count_q + LEN_WIDTH'(1);
          tlast_d = 1'b0;
          state_d = tlast_q ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // exactly with the state they describe.
    idle_d   = (state_d == S_IDLE);
    done_d   = (state_d == S_DONE);
    tvalid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      count_q  <= '0;
      tap_q    <= '0;
      acc_q    <= '0;
      hist_q   <= '{default: '0};
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      count_q  <= count_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      hist_q   <= hist_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
    end
  end

  assign ap_idle   = idle_q;
  assign ap_done   = done_q;
  assign sm_tvalid = tvalid_q;
  assign sm_tdata  = tdata_q;
  assign sm_tlast  = tlast_q;

endmodule

// File: tb/tb_fir_stream_engine.sv
// tb_fir_stream_engine
// Directed bench for fir_stream_engine with TAP_NUM=3. A queue models the
// FIFO, a small FIR model fills a scoreboard when each job is started and
// every output transfer is popped and compared against it.
module tb_fir_stream_engine;

  localparam int DW = 32;
  localparam int TN = 3;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start;
  logic [LW-1:0] data_length;
  logic          ap_idle;
  logic          ap_done;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [DW-1:0] coef_wdata;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_ready;
  logic          sm_tvalid;
  logic          sm_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;

  fir_stream_engine #(
    .DATA_WIDTH (DW),
    .TAP_NUM    (TN),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ap_start     (ap_start),
    .data_length  (data_length),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_wdata   (coef_wdata),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_r_ready (fifo_r_ready),
    .sm_tvalid    (sm_tvalid),
    .sm_tready    (sm_tready),
    .sm_tdata     (sm_tdata),
    .sm_tlast     (sm_tlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  int            tests_run    = 0;
  int            tests_failed = 0;
  logic [DW-1:0] fifo_mem [$];
  logic [DW-1:0] stim_q [$];
  exp_t          exp_q [$];
  logic [DW-1:0] model_c [TN];
  bit            starve;
  int            edge_count    = 0;
  int            last_pop_edge = 0;
  int            pops          = 0;
  int            xfers         = 0;
  int            done_count    = 0;
  int            rises         = 0;
  int            job_done_base = 0;
  logic          prev_tvalid   = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Present the head of the modelled FIFO; starve forces it to look empty.
  task automatic refreshFifo();
    fifo_empty = starve || (fifo_mem.size() == 0);
    fifo_data  = (fifo_mem.size() != 0) ? fifo_mem[0] : '0;
  endtask

  // One clock cycle, entered and left at a falling edge. Pops and transfers
  // are decided from the values just before the rising edge.
  task automatic tick();
    bit   pop;
    bit   xfer;
    exp_t e;
    #1;
    pop  = fifo_r_ready && !fifo_empty;
    xfer = sm_tvalid && sm_tready;
    if (sm_tvalid) checkOutput("no_pop_while_out", 32'(fifo_r_ready), 32'(0));
    if (xfer) begin
      checkOutput("sb_has_entry", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("tdata", sm_tdata, e.data);
        checkOutput("tlast", 32'(sm_tlast), 32'(e.last));
      end
    end
    @(posedge clk);
    edge_count++;
    if (pop) begin
      void'(fifo_mem.pop_front());
      pops++;
      last_pop_edge = edge_count;
    end
    if (xfer) xfers++;
    @(negedge clk);
    refreshFifo();
    if (ap_done) done_count++;
    if (sm_tvalid && !prev_tvalid) begin
      rises++;
      // Edges counted from the pop edge itself up to the edge raising tvalid.
      checkOutput("tvalid_latency", 32'(edge_count - last_pop_edge + 1), 32'(TN + 1));
    end
    prev_tvalid = sm_tvalid;
  endtask

  task automatic writeCoef(input int addr, input logic [DW-1:0] data);
    coef_we    = 1'b1;
    coef_addr  = 2'(addr);
    coef_wdata = data;
    tick();
    coef_we = 1'b0;
    if (addr < TN) model_c[addr] = data;
  endtask

  // Loads stim_q into the FIFO, fills the scoreboard and pulses ap_start.
  task automatic applyStimulus(input int len);
    logic [DW-1:0] h [TN];
    logic [DW-1:0] y;
    for (int k = 0; k < TN; k++) h[k] = '0;
    for (int n = 0; n < len; n++) begin
      for (int k = TN - 1; k > 0; k--) h[k] = h[k-1];
      h[0] = stim_q[n];
      y = '0;
      for (int k = 0; k < TN; k++) y = y + model_c[k] * h[k];
      fifo_mem.push_back(stim_q[n]);
      exp_q.push_back('{data: y, last: (n == len - 1)});
    end
    refreshFifo();
    data_length   = LW'(len);
    job_done_base = done_count;
    ap_start      = 1'b1;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic waitJob(input string name, input int budget);
    int i = 0;
    while (done_count == job_done_base && i < budget) begin
      tick();
      i++;
    end
    checkOutput({name, "_done"}, 32'(done_count - job_done_base), 32'(1));
    tick();
    tick();
    checkOutput({name, "_done_once"}, 32'(done_count - job_done_base), 32'(1));
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    checkOutput({name, "_idle"}, 32'(ap_idle), 32'(1));
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_ap_idle"}, 32'(ap_idle), 32'(1));
    checkOutput({name, "_ap_done"}, 32'(ap_done), 32'(0));
    checkOutput({name, "_fifo_r_ready"}, 32'(fifo_r_ready), 32'(0));
    checkOutput({name, "_tvalid"}, 32'(sm_tvalid), 32'(0));
    checkOutput({name, "_tdata"}, sm_tdata, 32'(0));
    checkOutput({name, "_tlast"}, 32'(sm_tlast), 32'(0));
  endtask

  initial begin
    int p0;
    int x0;
    int r0;
    int d0;
    int i;

    reset       = 1'b0;
    ap_start    = 1'b0;
    data_length = '0;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_wdata  = '0;
    sm_tready   = 1'b1;
    starve      = 1'b0;
    for (int k = 0; k < TN; k++) model_c[k] = '0;
    fifo_mem.push_back(32'h55);
    refreshFifo();
    @(negedge clk);

    // Reset held with a non-empty FIFO, then released into IDLE.
    repeat (3) tick();
    checkResetOutputs("reset");
    checkOutput("reset_no_pop", 32'(pops), 32'(0));
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("idle_no_pop", 32'(pops), 32'(0));
    checkOutput("idle_after_reset", 32'(ap_idle), 32'(1));
    fifo_mem.delete();
    refreshFifo();

    // Basic job: c={1,2,3}, x=1..4 -> 1,4,10,16. Address 3 does not exist.
    writeCoef(0, 32'd1);
    writeCoef(1, 32'd2);
    writeCoef(2, 32'd3);
    writeCoef(3, 32'd99);
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    applyStimulus(4);
    checkOutput("t2_busy", 32'(ap_idle), 32'(0));
    waitJob("t2", 200);

    // Backpressure on the second result.
    x0 = xfers;
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    applyStimulus(4);
    i = 0;
    while (xfers == x0 && i < 50) begin tick(); i++; end
    sm_tready = 1'b0;
    i = 0;
    while (!sm_tvalid && i < 50) begin tick(); i++; end
    checkOutput("t3_pending", 32'(sm_tvalid), 32'(1));
    repeat (5) begin
      if (exp_q.size() != 0) begin
        checkOutput("t3_hold_tdata", sm_tdata, exp_q[0].data);
        checkOutput("t3_hold_tlast", 32'(sm_tlast), 32'(exp_q[0].last));
      end
      checkOutput("t3_hold_valid", 32'(sm_tvalid), 32'(1));
      checkOutput("t3_no_pop", 32'(fifo_r_ready), 32'(0));
      tick();
    end
    sm_tready = 1'b1;
    waitJob("t3", 200);

    // Starvation after the second sample has been popped.
    p0 = pops;
    x0 = xfers;
    stim_q = '{32'd5, 32'hFFFF_FFFF, 32'd7, 32'd100};
    applyStimulus(4);
    i = 0;
    while (pops < p0 + 2 && i < 50) begin tick(); i++; end
    starve = 1'b1;
    refreshFifo();
    i = 0;
    while (xfers < x0 + 2 && i < 50) begin tick(); i++; end
    checkOutput("t4_two_out", 32'(xfers - x0), 32'(2));
    repeat (10) begin
      checkOutput("t4_starve_ready", 32'(fifo_r_ready), 32'(0));
      checkOutput("t4_starve_valid", 32'(sm_tvalid), 32'(0));
      tick();
    end
    starve = 1'b0;
    refreshFifo();
    waitJob("t4", 200);

    // Wrapping product, and coef_we/ap_start ignored while busy.
    writeCoef(0, 32'hFFFF_FFFF);
    writeCoef(1, 32'd0);
    writeCoef(2, 32'd0);
    p0 = pops;
    stim_q = '{32'd2};
    applyStimulus(1);
    i = 0;
    while (pops == p0 && i < 50) begin tick(); i++; end
    coef_we     = 1'b1;
    coef_addr   = 2'd0;
    coef_wdata  = 32'd5;
    ap_start    = 1'b1;
    data_length = LW'(7);
    tick();
    coef_we  = 1'b0;
    ap_start = 1'b0;
    waitJob("t5_wrap", 200);
    stim_q = '{32'd3};
    applyStimulus(1);
    waitJob("t5_coef_kept", 200);

    // Zero-length job: done pulse only, the waiting sample stays put.
    fifo_mem.push_back(32'h77);
    refreshFifo();
    p0 = pops;
    x0 = xfers;
    r0 = rises;
    stim_q.delete();
    applyStimulus(0);
    waitJob("t5_zero", 20);
    checkOutput("t5_zero_no_pop", 32'(pops - p0), 32'(0));
    checkOutput("t5_zero_no_valid", 32'(rises - r0), 32'(0));
    fifo_mem.delete();
    refreshFifo();

    // Reset in the MAC phase of the second sample, then a clean rerun.
    writeCoef(0, 32'd1);
    writeCoef(1, 32'd2);
    writeCoef(2, 32'd3);
    p0 = pops;
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    applyStimulus(4);
    i = 0;
    while (pops < p0 + 2 && i < 50) begin tick(); i++; end
    tick();
    d0 = done_count;
    reset = 1'b0;
    tick();
    checkResetOutputs("t6_reset");
    exp_q.delete();
    fifo_mem.delete();
    refreshFifo();
    for (int k = 0; k < TN; k++) model_c[k] = '0;
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("t6_no_done", 32'(done_count - d0), 32'(0));
    writeCoef(0, 32'd1);
    writeCoef(1, 32'd2);
    writeCoef(2, 32'd3);
    stim_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    applyStimulus(4);
    waitJob("t6_rerun", 200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
